// File: rtl/register_pkg.sv
// Shared definitions for the datapath registers: default word width, word type and reset word.
package register_pkg;

    localparam int WORD_WIDTH = 16;

    typedef logic [WORD_WIDTH-1:0] word_t;

    localparam word_t WORD_RESET = 16'h0000;

endpackage : register_pkg

// File: rtl/register_bit.sv
// One-bit storage cell: synchronous active-high reset to RESET_VALUE, load-enabled capture of d.
module register_bit #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic d,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_VALUE;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : register_bit

// File: rtl/register_16.sv
// Generic WIDTH-bit datapath register built from register_bit cells.
// Define REGISTER_PARITY_EN to add a registered even-parity output (parity_out).
module register_16
    import register_pkg::*;
#(
    parameter int               WIDTH       = WORD_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(WORD_RESET)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
`ifdef REGISTER_PARITY_EN
    output logic             parity_out,
`endif
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] w_q;

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("register_16: WIDTH must be in 1..64");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        register_bit #(
            .RESET_VALUE (RESET_VALUE[i])
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .d     (data_in[i]),
            .q     (w_q[i])
        );
    end

    assign data_out = w_q;

`ifdef REGISTER_PARITY_EN
    // Parity is computed from the incoming word so it lands on the same edge as data_out.
    logic r_parity;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= ^RESET_VALUE;
        end else if (load) begin
            r_parity <= ^data_in;
        end
    end

    assign parity_out = r_parity;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!$isunknown(load)) else $error("register_16: X/Z on load while reset is low");
        end
    end
`endif

endmodule : register_16

// File: tb/tb_register_16.sv
// Directed bench for register_16: default 16-bit instance, a 1-bit instance and a non-zero reset-value instance.
module tb_register_16;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        load1;
    logic [0:0]  d1;
    logic [0:0]  q1;
    logic [15:0] rv_out;
`ifdef REGISTER_PARITY_EN
    logic        parity_out;
    logic        parity1;
    logic        rv_parity;
`endif

    localparam logic [15:0] RV = 16'hC3A4;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [0:0]  exp1_q[$];
    logic [15:0] m16 = '0;
    logic [0:0]  m1  = '0;

    always #5 clk = ~clk;

    register_16 u_dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data_in    (data_in),
`ifdef REGISTER_PARITY_EN
        .parity_out (parity_out),
`endif
        .data_out   (data_out)
    );

    register_16 #(.WIDTH(1), .RESET_VALUE(1'b1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .load       (load1),
        .data_in    (d1),
`ifdef REGISTER_PARITY_EN
        .parity_out (parity1),
`endif
        .data_out   (q1)
    );

    register_16 #(.WIDTH(16), .RESET_VALUE(RV)) u_dut_rv (
        .clk        (clk),
        .reset      (reset),
        .load       (1'b0),
        .data_in    (~data_in),
`ifdef REGISTER_PARITY_EN
        .parity_out (rv_parity),
`endif
        .data_out   (rv_out)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_outputs();
        logic [15:0] e16;
        logic [0:0]  e1;
        e16 = exp_q.pop_front();
        e1  = exp1_q.pop_front();
        check("data_out", data_out, e16);
        check("q1", {15'd0, q1}, {15'd0, e1});
        check("rv_out", rv_out, RV);
`ifdef REGISTER_PARITY_EN
        check("parity_out", {15'd0, parity_out}, {15'd0, ^e16});
        check("parity1", {15'd0, parity1}, {15'd0, e1});
        check("rv_parity", {15'd0, rv_parity}, {15'd0, ^RV});
`endif
    endtask

    // Drive one cycle on both instances, push the expected values, then compare after the edge.
    task automatic step(input logic rst, input logic ld, input logic [15:0] d,
                        input logic ld1, input logic d1v);
        reset   = rst;
        load    = ld;
        data_in = d;
        load1   = ld1;
        d1      = d1v;
        if (rst)      m16 = 16'h0000;
        else if (ld)  m16 = d;
        if (rst)      m1 = 1'b1;
        else if (ld1) m1 = d1v;
        exp_q.push_back(m16);
        exp1_q.push_back(m1);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    // data_in flips five times between edges; only the value present at the edge may be captured.
    task automatic toggle_cycle();
        reset = 1'b0;
        load  = 1'b1;
        load1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            data_in = ~data_in;
            check("no_comb_path", data_out, m16);
            if (k < 4) #2;
        end
        m16 = data_in;
        exp_q.push_back(m16);
        exp1_q.push_back(m1);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    initial begin
        reset   = 1'b1;
        load    = 1'b1;
        data_in = 16'hFFFF;
        load1   = 1'b1;
        d1      = 1'b0;
        @(negedge clk);

        step(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        step(1'b0, 1'b1, 16'hA5A5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h5A5A, 1'b0, 1'b1);

        data_in = 16'h3C3C;
        for (int i = 0; i < 4; i++) toggle_cycle();

        step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);

        step(1'b0, 1'b1, 16'h0007, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'hBEEF, 1'b1, ((i % 2) == 0));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'hBEEF, 1'b0, ((i % 2) == 0));

        for (int i = 0; i < 20; i++) begin
            step(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                 16'($urandom_range(0, 16'hFFFF)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_register_16
